// File: rtl/divisor_pkg.sv
// Shared FSM state encoding and fixed result constants for the divisor dispatcher.
package divisor_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ISSUE = 2'd1;
   localparam state_t ST_WAIT  = 2'd2;
   localparam state_t ST_HOLD  = 2'd3;

   // Divide-by-zero quotient is all ones; replicated to SIZE bits at the use site.
   localparam logic DIV0_COC_BIT = 1'b1;

endpackage

// File: rtl/divisor_fifo.sv
// Operand-pair queue feeding the dispatcher; head entry is visible without popping.
module divisor_fifo
   import divisor_pkg::*;
#(
   parameter int SIZE  = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [SIZE-1:0]          push_num,
   input  logic [SIZE-1:0]          push_den,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [SIZE-1:0]          head_num,
   output logic [SIZE-1:0]          head_den
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   logic [SIZE-1:0] mem_num [DEPTH];
   logic [SIZE-1:0] mem_den [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign full     = (count == CNT_MAX);
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign head_num = mem_num[rd_ptr];
   assign head_den = mem_den[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Storage carries no reset; entries are only read once count says they are valid.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_num[wr_ptr] <= push_num;
         mem_den[wr_ptr] <= push_den;
      end
   end

endmodule

// File: rtl/divisor_dispatcher.sv
// Queues operand pairs and issues them one at a time to an external divider,
// short-circuiting divide-by-zero and bounding the wait for the divider.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting for a queued pair; pops head when one is present
// ST_ISSUE | div_start asserted for this single cycle, timer loaded
// ST_WAIT  | divider busy; waits for div_done or timer terminal count
// ST_HOLD  | result presented until the consumer takes it
module divisor_dispatcher
   import divisor_pkg::*;
#(
   parameter int SIZE    = 8,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SIZE-1:0]          in_num,
   input  logic [SIZE-1:0]          in_den,
   output logic                     div_start,
   output logic [SIZE-1:0]          div_num,
   output logic [SIZE-1:0]          div_den,
   input  logic                     div_done,
   input  logic [SIZE-1:0]          div_coc,
   input  logic [SIZE-1:0]          div_res,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [SIZE-1:0]          out_coc,
   output logic [SIZE-1:0]          out_res,
   output logic                     out_div0,
   output logic                     out_err,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TMR_ONE  = TW'(1);

   state_t          state;
   logic [TW-1:0]   tmr;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   logic [SIZE-1:0] head_num;
   logic [SIZE-1:0] head_den;

   assign in_ready  = !full && !rst;
   assign push      = in_valid && in_ready;
   assign pop       = (state == ST_IDLE) && !empty;
   assign div_start = (state == ST_ISSUE);

   divisor_fifo #(
      .SIZE  (SIZE),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .pop      (pop),
      .push_num (in_num),
      .push_den (in_den),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .head_num (head_num),
      .head_den (head_den)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         tmr       <= '0;
         div_num   <= '0;
         div_den   <= '0;
         out_valid <= 1'b0;
         out_coc   <= '0;
         out_res   <= '0;
         out_div0  <= 1'b0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  if (head_den == '0) begin
                     out_coc   <= {SIZE{DIV0_COC_BIT}};
                     out_res   <= head_num;
                     out_div0  <= 1'b1;
                     out_err   <= 1'b0;
                     out_valid <= 1'b1;
                     state     <= ST_HOLD;
                  end else begin
                     div_num <= head_num;
                     div_den <= head_den;
                     state   <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               tmr   <= TMR_LOAD;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               // A done arriving on the terminal-count cycle still wins over the timeout.
               if (div_done) begin
                  out_coc   <= div_coc;
                  out_res   <= div_res;
                  out_div0  <= 1'b0;
                  out_err   <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= ST_HOLD;
               end else if (tmr == '0) begin
                  out_coc   <= '0;
                  out_res   <= '0;
                  out_div0  <= 1'b0;
                  out_err   <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= ST_HOLD;
               end else begin
                  tmr <= tmr - TMR_ONE;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_div0  <= 1'b0;
                  out_err   <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_divisor_dispatcher.sv
// Bench for divisor_dispatcher: directed latency/boundary cases plus a randomized run
// scored against an in-order queue of expected results.
module tb_divisor_dispatcher;

   localparam int SIZE    = 8;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 64;

   logic                   clk = 1'b0;
   logic                   rst = 1'b1;
   logic                   in_valid = 1'b0;
   logic                   in_ready;
   logic [SIZE-1:0]        in_num = '0;
   logic [SIZE-1:0]        in_den = '0;
   logic                   div_start;
   logic [SIZE-1:0]        div_num;
   logic [SIZE-1:0]        div_den;
   logic                   div_done = 1'b0;
   logic [SIZE-1:0]        div_coc = '0;
   logic [SIZE-1:0]        div_res = '0;
   logic                   out_valid;
   logic                   out_ready = 1'b0;
   logic [SIZE-1:0]        out_coc;
   logic [SIZE-1:0]        out_res;
   logic                   out_div0;
   logic                   out_err;
   logic [$clog2(DEPTH):0] count;

   int checks = 0;
   int errors = 0;

   // divider model knobs
   bit             stall     = 1'b0;
   bit             rand_mode = 1'b0;
   int             lat       = 8;
   int             starts    = 0;
   bit             busy      = 1'b0;
   int             cnt       = 0;
   logic [SIZE-1:0] lnum, lden;

   logic [17:0] exp_q [$];

   always #5 clk = ~clk;

   divisor_dispatcher #(
      .SIZE    (SIZE),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_num    (in_num),
      .in_den    (in_den),
      .div_start (div_start),
      .div_num   (div_num),
      .div_den   (div_den),
      .div_done  (div_done),
      .div_coc   (div_coc),
      .div_res   (div_res),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_coc   (out_coc),
      .out_res   (out_res),
      .out_div0  (out_div0),
      .out_err   (out_err),
      .count     (count)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit will_stall(input logic [SIZE-1:0] n);
      return stall || (rand_mode && n[3:0] == 4'hA);
   endfunction

   // Expected result for an accepted pair: {quotient, remainder, div0, err}
   function automatic logic [17:0] model(input logic [SIZE-1:0] n, input logic [SIZE-1:0] d);
      if (d == 0)        return {8'd255, n, 1'b1, 1'b0};
      if (will_stall(n)) return {8'd0, 8'd0, 1'b0, 1'b1};
      return {n / d, n % d, 1'b0, 1'b0};
   endfunction

   // Divider: answers lat cycles after a start, or never when stalled.
   always @(negedge clk) begin
      div_done = 1'b0;
      if (div_start && !rst) begin
         starts++;
         lnum = div_num;
         lden = div_den;
         busy = !will_stall(div_num);
         cnt  = rand_mode ? $urandom_range(1, 12) : lat;
      end else if (busy) begin
         cnt--;
         if (cnt == 0) begin
            div_done = 1'b1;
            div_coc  = lnum / lden;
            div_res  = lnum % lden;
            busy     = 1'b0;
         end
      end
   end

   // Scoreboard: accepted pairs in, handshaked results out, strictly in order.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() > 0) begin
               check_val("sb_result", {out_coc, out_res, out_div0, out_err}, exp_q[0]);
               void'(exp_q.pop_front());
            end else begin
               check_val("sb_depth", exp_q.size(), 1);
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(in_num, in_den));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input logic [SIZE-1:0] n, input logic [SIZE-1:0] d);
      in_valid = 1'b1;
      in_num   = n;
      in_den   = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_start(input string tag, output int n);
      n = 1;
      while (!div_start && n < 20) begin step(); n++; end
      check_val(tag, div_start, 1'b1);
   endtask

   task automatic wait_valid(input string tag, input int bound, output int n);
      n = 0;
      while (!out_valid && n < bound) begin step(); n++; end
      check_val(tag, out_valid, 1'b1);
   endtask

   task automatic accept();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_val("accept_clears_valid", out_valid, 1'b0);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      #1;
      check_val("rst_count", count, 0);
      check_val("rst_valid", out_valid, 1'b0);
      check_val("rst_in_ready", in_ready, 1'b0);
      check_val("rst_div_start", div_start, 1'b0);
      check_val("rst_div_operands", {div_num, div_den}, 0);
      check_val("rst_out", {out_coc, out_res, out_div0, out_err}, 0);
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, s0, acc;
      bit seen;

      step();
      apply_reset();
      check_val("ready_after_reset", in_ready, 1'b1);

      // 100/7 with an 8-cycle divider
      s0 = starts;
      lat = 8;
      in_valid = 1'b1; in_num = 8'd100; in_den = 8'd7;
      step();
      in_valid = 1'b0;
      n = 1;
      while (!div_start && n < 10) begin step(); n++; end
      check_val("t1_start_latency", n, 2);
      wait_valid("t1_valid", 20, n);
      check_val("t1_done_latency", n, 9);
      check_val("t1_start_once", starts, s0 + 1);
      check_val("t1_coc", out_coc, 14);
      check_val("t1_res", out_res, 2);
      check_val("t1_flags", {out_div0, out_err}, 2'b00);
      accept();

      // 55/0 bypasses the divider
      s0 = starts;
      push_one(8'd55, 8'd0);
      n = 1;
      while (!out_valid && n < 10) begin step(); n++; end
      check_val("t2_latency", n, 2);
      check_val("t2_no_start", starts, s0);
      check_val("t2_coc", out_coc, 255);
      check_val("t2_res", out_res, 55);
      check_val("t2_flags", {out_div0, out_err}, 2'b10);
      accept();
      check_val("t2_div0_cleared", out_div0, 1'b0);

      // divider never answers -> timeout result
      stall = 1'b1;
      push_one(8'd9, 8'd3);
      wait_start("t4_start", n);
      wait_valid("t4_valid", TIMEOUT + 10, n);
      check_val("t4_timeout_latency", n, TIMEOUT + 1);
      check_val("t4_err_result", {out_coc, out_res, out_div0, out_err}, {8'd0, 8'd0, 1'b0, 1'b1});
      accept();
      check_val("t4_err_cleared", out_err, 1'b0);
      stall = 1'b0;

      // back-pressure on the result holds off the next issue
      lat = 3;
      s0 = starts;
      push_one(8'd20, 8'd3);
      push_one(8'd30, 8'd4);
      wait_valid("t5_first_valid", 30, n);
      repeat (15) step();
      check_val("t5_held_valid", out_valid, 1'b1);
      check_val("t5_no_second_start", starts, s0 + 1);
      check_val("t5_held_result", {out_coc, out_res}, {8'd6, 8'd2});
      check_val("t5_queued", count, 1);
      accept();
      n = 0;
      while (starts == s0 + 1 && n < 10) begin step(); n++; end
      check_val("t5_second_start", starts, s0 + 2);
      wait_valid("t5_second_valid", 30, n);
      check_val("t5_second_result", {out_coc, out_res}, {8'd7, 8'd2});
      accept();

      // fill the queue behind a stalled divider
      stall = 1'b1;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_num   = 8'(i + 1);
         in_den   = 8'd3;
         if (in_ready) acc++;
         step();
      end
      in_valid = 1'b0;
      check_val("t3_accepted", acc, 5);
      check_val("t3_count_full", count, DEPTH);
      check_val("t3_ready_low", in_ready, 1'b0);
      apply_reset();
      stall = 1'b0;

      // reset in WAIT with 3 queued; the late done must be ignored
      lat = 20;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_num   = 8'(40 + i);
         in_den   = 8'd5;
         step();
      end
      in_valid = 1'b0;
      step(); step();
      check_val("t6_queued", count, 3);
      apply_reset();
      s0 = starts;
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
         seen |= out_valid;
         step();
      end
      check_val("t6_no_late_output", seen, 1'b0);
      check_val("t6_no_new_start", starts, s0);
      check_val("t6_count_zero", count, 0);

      // randomized traffic
      rand_mode = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         in_valid  = ($urandom_range(0, 2) != 0);
         in_num    = 8'($urandom_range(0, 255));
         in_den    = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
         out_ready = ($urandom_range(0, 3) != 0);
         step();
         if (count > DEPTH) check_val("rand_count_bound", count, DEPTH);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin step(); n++; end
      check_val("drain_empty", exp_q.size(), 0);
      step(); step();
      check_val("drain_count", count, 0);
      check_val("drain_valid", out_valid, 1'b0);
      rand_mode = 1'b0;
      out_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/divisor_dispatcher.md
DIVISOR_DISPATCHER -- requirements
Module: divisor_dispatcher

Interface
REQ-001 Parameter SIZE, default 8, operand/result width in bits.
REQ-002 Parameter DEPTH, default 4, operand queue entries (power of two, >=2).
REQ-003 Parameter TIMEOUT, default 64, max cycles waiting for div_done.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  operand pair offered.
REQ-007 in_ready  out  1  queue can accept.
REQ-008 in_num  in  SIZE  dividend.
REQ-009 in_den  in  SIZE  divisor.
REQ-010 div_start  out  1  one-cycle start pulse to divider.
REQ-011 div_num  out  SIZE  dividend to divider.
REQ-012 div_den  out  SIZE  divisor to divider.
REQ-013 div_done  in  1  divider result valid.
REQ-014 div_coc  in  SIZE  divider quotient.
REQ-015 div_res  in  SIZE  divider remainder.
REQ-016 out_valid  out  1  result held.
REQ-017 out_ready  in  1  consumer accepts result.
REQ-018 out_coc  out  SIZE  quotient.
REQ-019 out_res  out  SIZE  remainder.
REQ-020 out_div0  out  1  result produced for divisor zero.
REQ-021 out_err  out  1  result produced by timeout.
REQ-022 count  out  $clog2(DEPTH)+1  queued pairs.

Function
REQ-023 Push when in_valid && in_ready; in_ready = !full && !rst (combinational); no push at full even if popping same cycle.
REQ-024 Queue is FIFO; count increments on push, decrements on pop, unchanged on simultaneous push+pop.
REQ-025 FSM states IDLE, ISSUE, WAIT, HOLD, registered.
REQ-026 IDLE: if count>0 and head den==0 -> pop, load out_coc={SIZE{1}}, out_res=head num, out_div0=1, out_valid=1, go HOLD; no div_start.
REQ-027 IDLE: if count>0 and head den!=0 -> pop, register div_num/div_den, go ISSUE.
REQ-028 ISSUE: div_start=1 exactly this cycle; go WAIT; timeout counter cleared.
REQ-029 div_num/div_den stable from ISSUE until WAIT exits.
REQ-030 WAIT: on div_done capture div_coc/div_res into out_coc/out_res, out_valid=1, flags 0, go HOLD.
REQ-031 WAIT: after TIMEOUT cycles without div_done, out_coc=0, out_res=0, out_err=1, out_valid=1, go HOLD.
REQ-032 div_done ignored outside WAIT.
REQ-033 HOLD: outputs stable while out_valid && !out_ready; on out_ready, out_valid=0, flags cleared, go IDLE.
REQ-034 Latency: push into empty queue at cycle t -> div_start at t+2; div_done at cycle d -> out_valid at d+1.
REQ-035 At most one division outstanding; queue keeps accepting during WAIT/HOLD.

Reset
REQ-036 rst asserted: immediately FSM IDLE, count=0, queue empty, div_start=0, div_num=div_den=0, out_valid=0, out_coc=out_res=0, out_div0=out_err=0, in_ready=0.
REQ-037 rst mid-WAIT discards in-flight and queued operations; later div_done ignored until next ISSUE.

Structure
REQ-038 Package divisor_pkg holds FSM state typedef and DIV0 quotient constant.
REQ-039 Queue is sub-module divisor_fifo (SIZE, DEPTH params: push, pop, full, empty, count, head num/den).

Verification
REQ-040 Push 100/7, divider returns done after 8 cycles -> div_start once at t+2, out_coc=14, out_res=2.
REQ-041 Push 55/0 -> no div_start, out_coc=255, out_res=55, out_div0=1.
REQ-042 Divider stalled, push 5 pairs -> 4 accepted after issue slot used, in_ready=0 when count=4.
REQ-043 out_ready held 0, two pairs queued -> second div_start not issued until first result accepted.
REQ-044 div_done never asserted -> out_err=1 exactly TIMEOUT+1 cycles after div_start.
REQ-045 rst asserted in WAIT with 3 queued -> count=0, out_valid=0, late div_done produces no output.
